// File: rtl/csm_multiport_mem.sv
// csm_multiport_mem: N-port shared register memory, round-robin arbitration, exclusive hold lock
// Optional HOLD_TIMEOUT_EN: an idle hold auto-expires after HOLD_TIMEOUT cycles
module csm_multiport_mem #(
  parameter int N_PORTS      = 2,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int HOLD_TIMEOUT = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PID_W  = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [2*N_PORTS-1:0]      req_op,
  input  logic [ADDR_W*N_PORTS-1:0] req_addr,
  input  logic [DATA_W*N_PORTS-1:0] req_wdata,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [DATA_W*N_PORTS-1:0] rsp_rdata,
  output logic [N_PORTS-1:0]        rsp_err,
  output logic                      hold_active,
  output logic [PID_W-1:0]          hold_owner,
  output logic                      hold_expired
);
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_HOLD = 2'b10, OP_REL = 2'b11;
  logic [PID_W-1:0] rr_ptr_q, rr_ptr_d, hold_owner_q, hold_owner_d, gid;
  logic hold_active_q, hold_active_d, hold_expired_q, hold_expired_d;
  logic found, err, ok, is_owner, expire;
  logic [1:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W*N_PORTS-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef HOLD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif
  always_comb begin
    found = 1'b0;
    gid = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + i) % N_PORTS]) begin
        found = 1'b1;
        gid = PID_W'((int'(rr_ptr_q) + i) % N_PORTS);
      end
    end
  end
  assign req_ready = found ? (N_PORTS'(1) << gid) : '0;
  always_comb begin
    op = req_op[2*int'(gid) +: 2];
    addr = req_addr[ADDR_W*int'(gid) +: ADDR_W];
    wdata = req_wdata[DATA_W*int'(gid) +: DATA_W];
    is_owner = hold_active_q && hold_owner_q == gid;
    err = int'(addr) >= DEPTH || (hold_active_q && !is_owner) || (!hold_active_q && op == OP_REL);
    ok = found && !err;
    rdata = (ok && op == OP_RD) ? mem_q[addr] : '0;
    mem_d = mem_q;
    if (ok && op == OP_WR) mem_d[addr] = wdata;
    rsp_valid_d = req_ready;
    rsp_err_d = err ? req_ready : '0;
    rsp_rdata_d = '0;
    rsp_rdata_d[DATA_W*int'(gid) +: DATA_W] = rdata;
    rr_ptr_d = found ? ((int'(gid) == N_PORTS - 1) ? '0 : gid + 1'b1) : rr_ptr_q;
`ifdef HOLD_TIMEOUT_EN
    cnt_d = (!hold_active_q || (found && is_owner)) ? '0 : cnt_q + 16'd1;
    // an owner op accepted in the expiry cycle keeps the lock alive
    expire = hold_active_q && !(found && is_owner) && cnt_d == 16'(HOLD_TIMEOUT);
`else
    expire = 1'b0;
`endif
    hold_expired_d = expire;
    hold_active_d = hold_active_q;
    hold_owner_d = hold_owner_q;
    if (ok && op == OP_HOLD && !hold_active_q) begin
      hold_active_d = 1'b1;
      hold_owner_d = gid;
    end
    if ((ok && op == OP_REL) || expire) begin
      hold_active_d = 1'b0;
      hold_owner_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rr_ptr_q <= '0;
      hold_active_q <= 1'b0;
      hold_owner_q <= '0;
      hold_expired_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q <= '0;
      rsp_rdata_q <= '0;
`ifdef HOLD_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      mem_q <= mem_d;
      rr_ptr_q <= rr_ptr_d;
      hold_active_q <= hold_active_d;
      hold_owner_q <= hold_owner_d;
      hold_expired_q <= hold_expired_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef HOLD_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign hold_active = hold_active_q;
  assign hold_owner = hold_owner_q;
  assign hold_expired = hold_expired_q;
endmodule

// File: tb/tb_csm_multiport_mem.sv
// tb_csm_multiport_mem: table-driven and scoreboard checks of csm_multiport_mem (4 ports, 5 words)
module tb_csm_multiport_mem;
  localparam int N = 4, W = 8, D = 5, AW = 3, PW = 2;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, HO = 2'b10, RL = 2'b11;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_err;
  logic [2*N-1:0] req_op = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [W*N-1:0] req_wdata = '0, rsp_rdata;
  logic hold_active, hold_expired;
  logic [PW-1:0] hold_owner;
  int n_cmp = 0, n_fail = 0;
  typedef struct {
    int port; logic [1:0] op; logic [AW-1:0] addr; logic [W-1:0] wd;
    logic err; logic [W-1:0] rd; logic act; logic [PW-1:0] own;
  } vec_t;
  typedef struct { int port; logic err; logic [W-1:0] rd; logic act; logic [PW-1:0] own; } sb_t;
  sb_t q[$];
  vec_t tbl[22];

  csm_multiport_mem #(.N_PORTS(N), .DATA_W(W), .DEPTH(D), .HOLD_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .hold_active(hold_active), .hold_owner(hold_owner), .hold_expired(hold_expired));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid != '0) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        sb_t e;
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.port));
        chk("rsp_err", 32'(rsp_err[e.port]), 32'(e.err));
        chk("rsp_rdata", 32'(rsp_rdata[W*e.port +: W]), 32'(e.rd));
        chk("hold_active", 32'(hold_active), 32'(e.act));
        chk("hold_owner", 32'(hold_owner), 32'(e.own));
      end
    end
  end

  task automatic set_port(input int p, input logic [1:0] op, input logic [AW-1:0] a, input logic [W-1:0] wd);
    req_valid[p] = 1'b1;
    req_op[2*p +: 2] = op;
    req_addr[AW*p +: AW] = a;
    req_wdata[W*p +: W] = wd;
  endtask

  task automatic issue(input vec_t v);
    bit ok = 0;
    req_valid = '0;
    set_port(v.port, v.op, v.addr, v.wd);
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[v.port]) begin
        ok = 1;
        chk("req_ready", 32'(req_ready), 32'(1 << v.port));
        q.push_back('{v.port, v.err, v.rd, v.act, v.own});
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_hold_active"}, 32'(hold_active), 32'd0);
    chk({tag, "_hold_owner"}, 32'(hold_owner), 32'd0);
    chk({tag, "_hold_expired"}, 32'(hold_expired), 32'd0);
  endtask

  initial begin
    logic [W-1:0] t3_rd [N];
    tbl[0]  = '{0, WR, 3'd2, 8'hA5, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1, RD, 3'd2, 8'h00, 1'b0, 8'hA5, 1'b0, 2'd0};
    tbl[2]  = '{2, WR, 3'd4, 8'h3C, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[3]  = '{3, RD, 3'd4, 8'h00, 1'b0, 8'h3C, 1'b0, 2'd0};
    tbl[4]  = '{0, RD, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[5]  = '{1, RL, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 2'd0};
    tbl[6]  = '{2, RD, 3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 2'd0};
    tbl[7]  = '{3, WR, 3'd5, 8'hFF, 1'b1, 8'h00, 1'b0, 2'd0};
    tbl[8]  = '{0, RD, 3'd4, 8'h00, 1'b0, 8'h3C, 1'b0, 2'd0};
    tbl[9]  = '{0, HO, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[10] = '{1, RD, 3'd1, 8'h00, 1'b1, 8'h00, 1'b1, 2'd0};
    tbl[11] = '{1, WR, 3'd1, 8'h77, 1'b1, 8'h00, 1'b1, 2'd0};
    tbl[12] = '{0, WR, 3'd1, 8'h11, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[13] = '{0, HO, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[14] = '{2, RL, 3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 2'd0};
    tbl[15] = '{0, RL, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[16] = '{1, RD, 3'd1, 8'h00, 1'b0, 8'h11, 1'b0, 2'd0};
    tbl[17] = '{2, HO, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd2};
    tbl[18] = '{2, RD, 3'd2, 8'h00, 1'b0, 8'hA5, 1'b1, 2'd2};
    tbl[19] = '{3, RD, 3'd2, 8'h00, 1'b1, 8'h00, 1'b1, 2'd2};
    tbl[20] = '{2, RL, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[21] = '{3, RD, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
    t3_rd = '{8'h11, 8'hA5, 8'h00, 8'h3C};
    #12 check_reset_outputs("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    foreach (tbl[i]) issue(tbl[i]);
    // all ports read continuously from rr_ptr=0: grants rotate 0,1,2,3,0,...
    for (int p = 0; p < N; p++) set_port(p, RD, AW'((p + 1) % D), 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
      q.push_back('{k % N, 1'b0, t3_rd[k % N], 1'b0, 2'd0});
      @(posedge clk); #1;
    end
    req_valid = '0;
    issue('{0, RD, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0});
    set_port(0, HO, 3'd0, 8'h00);
    set_port(1, HO, 3'd0, 8'h00);
    @(negedge clk);
    chk("hold_race_winner", 32'(req_ready), 32'h2);
    q.push_back('{1, 1'b0, 8'h00, 1'b1, 2'd1});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("hold_race_loser", 32'(req_ready), 32'h1);
    q.push_back('{0, 1'b1, 8'h00, 1'b1, 2'd1});
    @(posedge clk); #1;
    req_valid = '0;
    issue('{1, RL, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0});
    issue('{2, HO, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd2});
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    issue('{1, RD, 3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0});
`ifdef HOLD_TIMEOUT_EN
    issue('{3, HO, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 2'd3});
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("to_still_held", 32'({hold_active, hold_expired}), 32'b10);
    end
    @(posedge clk); #1;
    chk("to_expired", 32'({hold_active, hold_expired, hold_owner}), 32'b0100);
    @(posedge clk); #1;
    chk("to_pulse_end", 32'(hold_expired), 32'd0);
    issue('{1, WR, 3'd3, 8'h5A, 1'b0, 8'h00, 1'b0, 2'd0});
    issue('{2, RD, 3'd3, 8'h00, 1'b0, 8'h5A, 1'b0, 2'd0});
`endif
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
